debouncer: RTL

- Multi-channel input debouncer; the consumer of the periodic timer's one-cycle `tick` strobe.
- Synchronises raw asynchronous inputs (buttons, switches, jumpers) into the `clk_in` domain.
- Accepts a level change only after it is stable for STABLE_TICKS consecutive ticks.
- Emits a clean level per channel plus one-cycle rise/fall pulses for downstream control logic.

---
 rtl/debouncer_pkg.sv | 14 +
 rtl/debouncer_channel.sv | 62 ++++++
 rtl/debouncer.sv | 34 +++
 3 files changed

// File: rtl/debouncer_pkg.sv
// Shared helpers for the debouncer: counter sizing.
package debouncer_pkg;

  // Smallest width able to count 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 17; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debouncer_channel.sv
// One debounce channel: two-flop synchroniser, stability counter and
// registered level / rise / fall outputs.
module debounce_channel
  import debouncer_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = 4,
  parameter logic        INIT_LEVEL   = 1'b0
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic tick_in,
  input  logic raw_in,
  output logic level_out,
  output logic rise_out,
  output logic fall_out
);

  localparam int CNT_W = cnt_width(int'(STABLE_TICKS));
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_TICKS - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous input into the clock domain; runs every cycle.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      sync_p0 <= INIT_LEVEL;
      sync_p1 <= INIT_LEVEL;
    end else begin
      sync_p0 <= raw_in;
      sync_p1 <= sync_p0;
    end
  end

  // Count consecutive disagreeing tick samples; commit the new level on the last one.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      cnt       <= '0;
      level_out <= INIT_LEVEL;
      rise_out  <= 1'b0;
      fall_out  <= 1'b0;
    end else begin
      rise_out <= 1'b0;
      fall_out <= 1'b0;
      if (tick_in) begin
        if (sync_p1 == level_out) begin
          // Any agreeing sample throws away accumulated progress.
          cnt <= '0;
        end else if (cnt == CNT_MAX) begin
          cnt       <= '0;
          level_out <= sync_p1;
          rise_out  <= sync_p1;
          fall_out  <= ~sync_p1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/debouncer.sv
// Multi-channel debouncer: NUM_INPUTS independent channels sharing the
// sample strobe and reset.
module debouncer
  import debouncer_pkg::*;
#(
  parameter int unsigned NUM_INPUTS   = 4,
  parameter int unsigned STABLE_TICKS = 4,
  parameter logic        INIT_LEVEL   = 1'b0
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  tick_in,
  input  logic [NUM_INPUTS-1:0] raw_in,
  output logic [NUM_INPUTS-1:0] level_out,
  output logic [NUM_INPUTS-1:0] rise_out,
  output logic [NUM_INPUTS-1:0] fall_out
);

  for (genvar g = 0; g < int'(NUM_INPUTS); g++) begin : g_chan
    debounce_channel #(
      .STABLE_TICKS (STABLE_TICKS),
      .INIT_LEVEL   (INIT_LEVEL)
    ) u_chan (
      .clk_in    (clk_in),
      .reset_in  (reset_in),
      .tick_in   (tick_in),
      .raw_in    (raw_in[g]),
      .level_out (level_out[g]),
      .rise_out  (rise_out[g]),
      .fall_out  (fall_out[g])
    );
  end

endmodule
